// File: rtl/pe_control_sequencer_if.sv
// pe_control_sequencer_if: scheduler-side handshake plus the control-word bus
// between the layer scheduler (master) and the PE control sequencer (slave).
interface pe_control_sequencer_if #(
    parameter int unsigned depth = 2,
    parameter int unsigned A     = 7
);
    logic             start;
    logic             stall;
    logic [A-1:0]     kRows;
    logic [A-1:0]     kCols;
    logic [depth-1:0] kRowOfst;
    logic [depth-1:0] kColOfst;
    logic [depth-1:0] nRowOfst;
    logic [depth-1:0] nColOfst;
    logic [5:0]       controlSignal;
    logic [depth-1:0] initSettings;
    logic             macValid;
    logic             busy;
    logic             done;

    modport master (
        output start, stall, kRows, kCols, kRowOfst, kColOfst, nRowOfst, nColOfst,
        input  controlSignal, initSettings, macValid, busy, done
    );

    modport slave (
        input  start, stall, kRows, kCols, kRowOfst, kColOfst, nRowOfst, nColOfst,
        output controlSignal, initSettings, macValid, busy, done
    );
endinterface

// File: rtl/pe_control_sequencer.sv
// pe_control_sequencer: global-side driver for the per-PE local store controllers.
// Emits the 6-bit control word {kernelCtrl, neuronCtrl} and initSettings for one
// kernel-window pass: offset loads, INIT, then row-major INCR bursts split by JUMPs.
// Optional macro PE_SEQ_OFFSET_LOAD_EN: when defined, the four offset-load (SET)
// words precede INIT; when undefined, IDLE goes straight to INIT and initSettings is 0.
module pe_control_sequencer #(
    parameter int unsigned depth = 2,
    parameter int unsigned A     = 7
) (
    input logic                   CLK,
    input logic                   RST,
    pe_control_sequencer_if.slave bus
);
    localparam logic [2:0] OpInit    = 3'b000;
    localparam logic [2:0] OpHold    = 3'b001;
    localparam logic [2:0] OpIncr    = 3'b010;
    localparam logic [2:0] OpJump    = 3'b011;
    localparam logic [2:0] OpSetKRow = 3'b100;
    localparam logic [2:0] OpSetKCol = 3'b101;
    localparam logic [2:0] OpSetNRow = 3'b110;
    localparam logic [2:0] OpSetNCol = 3'b111;

    // The state names the word currently on the outputs; each transition also
    // registers the word of the state being entered.
    typedef enum logic [3:0] {
        StIdle,
        StSetKr,
        StSetKc,
        StSetNr,
        StSetNc,
        StInit,
        StRun,
        StJump,
        StDone
    } state_e;

    state_e           state_q;
    logic [A-1:0]     rows_q;
    logic [A-1:0]     cols_q;
    logic [A-1:0]     row_q;
    logic [A-1:0]     col_q;
    logic [5:0]       ctrl_q;
    logic [depth-1:0] init_q;
    logic             mac_q;
    logic             busy_q;
    logic             done_q;

`ifdef PE_SEQ_OFFSET_LOAD_EN
    // kRowOfst is consumed on the start edge itself, so only three need holding.
    logic [depth-1:0] kc_ofst_q;
    logic [depth-1:0] nr_ofst_q;
    logic [depth-1:0] nc_ofst_q;
`else
    logic unused_ofst;
    assign unused_ofst = ^{bus.kRowOfst, bus.kColOfst, bus.nRowOfst, bus.nColOfst};
`endif

    // Drive the bus straight from the registered outputs.
    assign bus.controlSignal = ctrl_q;
    assign bus.initSettings  = init_q;
    assign bus.macValid      = mac_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

    // Sequencer FSM: state, counters, latched pass parameters and outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            rows_q    <= '0;
            cols_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            ctrl_q    <= {OpHold, OpHold};
            init_q    <= '0;
            mac_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef PE_SEQ_OFFSET_LOAD_EN
            kc_ofst_q <= '0;
            nr_ofst_q <= '0;
            nc_ofst_q <= '0;
`endif
        end else begin
            // Default next word: HOLD/HOLD, no side fields, still inside the pass.
            ctrl_q <= {OpHold, OpHold};
            init_q <= '0;
            mac_q  <= 1'b0;
            busy_q <= 1'b1;
            done_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        rows_q    <= bus.kRows;
                        cols_q    <= bus.kCols;
                        row_q     <= '0;
                        col_q     <= '0;
                        busy_q    <= 1'b1;
`ifdef PE_SEQ_OFFSET_LOAD_EN
                        kc_ofst_q <= bus.kColOfst;
                        nr_ofst_q <= bus.nRowOfst;
                        nc_ofst_q <= bus.nColOfst;
                        state_q   <= StSetKr;
                        ctrl_q    <= {OpSetKRow, OpHold};
                        init_q    <= bus.kRowOfst;
`else
                        state_q   <= StInit;
                        ctrl_q    <= {OpInit, OpInit};
`endif
                    end
                end

`ifdef PE_SEQ_OFFSET_LOAD_EN
                StSetKr: begin
                    state_q <= StSetKc;
                    ctrl_q  <= {OpSetKCol, OpHold};
                    init_q  <= kc_ofst_q;
                end

                StSetKc: begin
                    state_q <= StSetNr;
                    ctrl_q  <= {OpHold, OpSetNRow};
                    init_q  <= nr_ofst_q;
                end

                StSetNr: begin
                    state_q <= StSetNc;
                    ctrl_q  <= {OpHold, OpSetNCol};
                    init_q  <= nc_ofst_q;
                end

                StSetNc: begin
                    state_q <= StInit;
                    ctrl_q  <= {OpInit, OpInit};
                    row_q   <= '0;
                    col_q   <= '0;
                end
`endif

                StInit: begin
                    row_q <= '0;
                    col_q <= '0;
                    if (rows_q == '0 || cols_q == '0) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= StRun;
                        ctrl_q  <= {OpIncr, OpIncr};
                        mac_q   <= 1'b1;
                    end
                end

                // col_q indexes the last INCR issued in this row; a stall leaves it
                // untouched so the sweep resumes at the same position.
                StRun: begin
                    if (bus.stall) begin
                        state_q <= StRun;
                    end else if (col_q == cols_q - A'(1)) begin
                        state_q <= StJump;
                        ctrl_q  <= {OpJump, OpJump};
                    end else begin
                        col_q  <= col_q + A'(1);
                        ctrl_q <= {OpIncr, OpIncr};
                        mac_q  <= 1'b1;
                    end
                end

                StJump: begin
                    col_q <= '0;
                    row_q <= row_q + A'(1);
                    if (row_q == rows_q - A'(1)) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= StRun;
                        ctrl_q  <= {OpIncr, OpIncr};
                        mac_q   <= 1'b1;
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule
